// File: rtl/mem_access_unit.sv
// Data-memory access stage: runs a valid/ready bus transaction for loads and
// stores, formats load data, stalls the datapath and flags bad accesses.
//
// Ports:
//   clk, rst (async, active-low)
//   mem_req, mem_we, funct3, addr, wdata   - request from the datapath
//   rdata, stall, fault                    - results back to the datapath
//   bus_valid, bus_we, bus_addr, bus_be,
//   bus_wdata, bus_ready, bus_rdata        - memory bus
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        fault,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata
);

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        DONE
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  count_q, count_d;
    logic [31:0] rdata_q, rdata_d;
    logic        fault_q, fault_d;
    logic        bus_valid_q, bus_valid_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [1:0]  lane_q, lane_d;
    logic [2:0]  f3_q, f3_d;

    logic        bad_f3;
    logic        misaligned;
    logic        legal;
    logic [3:0]  be;
    logic [31:0] wdata_rep;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_fmt;

    // Request decode
    always_comb begin
        if (mem_we) begin
            bad_f3 = (funct3 > 3'b010);
        end else begin
            bad_f3 = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
        end
        misaligned = ((funct3[1:0] == 2'b01) && addr[0])
                  || ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        legal = !bad_f3 && !misaligned;
        unique case (funct3[1:0])
            2'b00: begin
                be        = 4'b0001 << addr[1:0];
                wdata_rep = {4{wdata[7:0]}};
            end
            2'b01: begin
                be        = 4'b0011 << addr[1:0];
                wdata_rep = {2{wdata[15:0]}};
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = wdata;
            end
        endcase
    end

    // Load formatting uses the lane and size latched at request time
    always_comb begin
        byte_sel = 8'(bus_rdata >> {lane_q, 3'b000});
        half_sel = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        unique case (f3_q)
            3'b000:  load_fmt = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_fmt = {24'd0, byte_sel};
            3'b001:  load_fmt = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_fmt = {16'd0, half_sel};
            default: load_fmt = bus_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rdata_d     = rdata_q;
        fault_d     = 1'b0;
        bus_valid_d = bus_valid_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        lane_d      = lane_q;
        f3_d        = f3_q;
        unique case (state_q)
            IDLE: begin
                bus_valid_d = 1'b0;
                if (mem_req) begin
                    if (legal) begin
                        bus_valid_d = 1'b1;
                        bus_we_d    = mem_we;
                        bus_addr_d  = {addr[31:2], 2'b00};
                        bus_be_d    = be;
                        bus_wdata_d = wdata_rep;
                        lane_d      = addr[1:0];
                        f3_d        = funct3;
                        count_d     = 8'd0;
                        state_d     = BUS;
                    end else begin
                        // Bad access commits at once with zero data
                        fault_d = 1'b1;
                        rdata_d = 32'd0;
                    end
                end
            end
            BUS: begin
                if (bus_ready) begin
                    rdata_d     = bus_we_q ? 32'd0 : load_fmt;
                    bus_valid_d = 1'b0;
                    state_d     = DONE;
                end else if (count_q == LAST) begin
                    rdata_d     = 32'd0;
                    fault_d     = 1'b1;
                    bus_valid_d = 1'b0;
                    state_d     = DONE;
                end else begin
                    count_d = count_q + 8'd1;
                end
            end
            DONE: begin
                bus_valid_d = 1'b0;
                state_d     = IDLE;
            end
            default: begin
                bus_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            count_q     <= 8'd0;
            rdata_q     <= 32'd0;
            fault_q     <= 1'b0;
            bus_valid_q <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_be_q    <= 4'd0;
            bus_wdata_q <= 32'd0;
            lane_q      <= 2'd0;
            f3_q        <= 3'd0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rdata_q     <= rdata_d;
            fault_q     <= fault_d;
            bus_valid_q <= bus_valid_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            lane_q      <= lane_d;
            f3_q        <= f3_d;
        end
    end

    assign stall     = mem_req && legal && (state_q != DONE);
    assign rdata     = rdata_q;
    assign fault     = fault_q;
    assign bus_valid = bus_valid_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: table of single accesses plus
// hand-written reset, timeout and idle-ready sequences.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic        mem_we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        fault;
    logic        bus_valid;
    logic        bus_ready;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we),
        .funct3(funct3), .addr(addr), .wdata(wdata), .rdata(rdata),
        .stall(stall), .fault(fault), .bus_valid(bus_valid),
        .bus_ready(bus_ready), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
    );

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rin;
        int          waits;
        int          exp_nvalid;
        logic        exp_fault;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int  nv;
        bit  done;
        nv   = 0;
        done = 1'b0;
        @(posedge clk); #1;
        mem_req   = 1'b1;
        mem_we    = v.we;
        funct3    = v.f3;
        addr      = v.addr;
        wdata     = v.wdata;
        bus_rdata = v.rin;
        bus_ready = 1'b0;
        @(negedge clk);
        chk("stall_idle", 32'(stall), 32'(v.exp_nvalid != 0));
        if (v.exp_nvalid == 0) begin
            chk("valid_bad_idle", 32'(bus_valid), 32'd0);
            @(posedge clk); #1;
            mem_req = 1'b0;
            @(negedge clk);
            chk("fault_bad", 32'(fault), 32'd1);
            chk("valid_bad", 32'(bus_valid), 32'd0);
            chk("rdata_bad", rdata, 32'd0);
            chk("stall_bad", 32'(stall), 32'd0);
            @(negedge clk);
            chk("fault_bad_end", 32'(fault), 32'd0);
            chk("valid_bad_end", 32'(bus_valid), 32'd0);
        end else begin
            for (int k = 0; k < 40 && !done; k++) begin
                @(negedge clk);
                if (bus_valid) begin
                    nv++;
                    chk("bus_addr", bus_addr, v.addr & 32'hFFFF_FFFC);
                    chk("bus_be", 32'(bus_be), 32'(v.exp_be));
                    chk("bus_we", 32'(bus_we), 32'(v.we));
                    chk("bus_wdata", bus_wdata, v.exp_wdata);
                    chk("stall_bus", 32'(stall), 32'd1);
                    bus_ready = (nv == v.waits + 1);
                end else begin
                    done = 1'b1;
                end
            end
            bus_ready = 1'b0;
            if (!done) chk("bus_bounded", 32'd0, 32'd1);
            chk("nvalid", 32'(nv), 32'(v.exp_nvalid));
            chk("rdata_done", rdata, v.exp_rdata);
            chk("fault_done", 32'(fault), 32'(v.exp_fault));
            chk("stall_done", 32'(stall), 32'd0);
            @(posedge clk); #1;
            mem_req = 1'b0;
            @(negedge clk);
            chk("fault_idle", 32'(fault), 32'd0);
            chk("valid_idle", 32'(bus_valid), 32'd0);
            chk("rdata_hold", rdata, v.exp_rdata);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rdata"}, rdata, 32'd0);
        chk({tag, "_fault"}, 32'(fault), 32'd0);
        chk({tag, "_valid"}, 32'(bus_valid), 32'd0);
        chk({tag, "_we"}, 32'(bus_we), 32'd0);
        chk({tag, "_addr"}, bus_addr, 32'd0);
        chk({tag, "_be"}, 32'(bus_be), 32'd0);
        chk({tag, "_wdata"}, bus_wdata, 32'd0);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t r;
        // we f3 addr wdata rin waits nvalid fault be wdata_exp rdata_exp
        vecs[0]  = '{0, 3'b010, 32'h100,  32'h0, 32'hDEADBEEF, 2, 3, 0,
                     4'b1111, 32'h0, 32'hDEADBEEF};
        vecs[1]  = '{0, 3'b001, 32'h3001, 32'h0, 32'h0, 0, 0, 1,
                     4'b0000, 32'h0, 32'h0};
        vecs[2]  = '{0, 3'b000, 32'h2001, 32'h0, 32'h00008000, 0, 1, 0,
                     4'b0010, 32'h0, 32'hFFFFFF80};
        vecs[3]  = '{0, 3'b010, 32'h500,  32'h0, 32'h11111111, 99, 4, 1,
                     4'b1111, 32'h0, 32'h0};
        vecs[4]  = '{0, 3'b100, 32'h2001, 32'h0, 32'h00008000, 1, 2, 0,
                     4'b0010, 32'h0, 32'h00000080};
        vecs[5]  = '{0, 3'b001, 32'h2002, 32'h0, 32'h80010000, 0, 1, 0,
                     4'b1100, 32'h0, 32'hFFFF8001};
        vecs[6]  = '{1, 3'b000, 32'h1003, 32'h123456AB, 32'h0, 3, 4, 0,
                     4'b1000, 32'hABABABAB, 32'h0};
        vecs[7]  = '{0, 3'b101, 32'h2002, 32'h0, 32'h80010000, 0, 1, 0,
                     4'b1100, 32'h0, 32'h00008001};
        vecs[8]  = '{0, 3'b010, 32'h3002, 32'h0, 32'h0, 0, 0, 1,
                     4'b0000, 32'h0, 32'h0};
        vecs[9]  = '{0, 3'b000, 32'h2003, 32'h0, 32'h7F000000, 0, 1, 0,
                     4'b1000, 32'h0, 32'h0000007F};
        vecs[10] = '{1, 3'b001, 32'h2002, 32'h0000BEEF, 32'h0, 1, 2, 0,
                     4'b1100, 32'hBEEFBEEF, 32'h0};
        vecs[11] = '{0, 3'b011, 32'h10,   32'h0, 32'h0, 0, 0, 1,
                     4'b0000, 32'h0, 32'h0};
        vecs[12] = '{1, 3'b010, 32'h40,   32'hCAFEF00D, 32'h0, 0, 1, 0,
                     4'b1111, 32'hCAFEF00D, 32'h0};
        vecs[13] = '{1, 3'b100, 32'h44,   32'h55, 32'h0, 0, 0, 1,
                     4'b0000, 32'h0, 32'h0};

        rst = 1'b0; mem_req = 1'b0; mem_we = 1'b0; funct3 = 3'd0;
        addr = 32'd0; wdata = 32'd0; bus_ready = 1'b0; bus_rdata = 32'd0;
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        #2 rst = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Leave a nonzero rdata, then reset in the middle of a bus cycle
        r = '{0, 3'b010, 32'h600, 32'h0, 32'h12345678, 0, 1, 0,
              4'b1111, 32'h0, 32'h12345678};
        run_vec(r);
        @(posedge clk); #1;
        mem_req = 1'b1; mem_we = 1'b0; funct3 = 3'b010; addr = 32'h700;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_valid", 32'(bus_valid), 32'd1);
        chk("pre_rst_addr", bus_addr, 32'h700);
        #2 rst = 1'b0; mem_req = 1'b0;
        #1 chk_reset_vals("async_rst");
        @(negedge clk);
        chk_reset_vals("held_rst");
        #2 rst = 1'b1;

        // Ready while idle must be ignored
        bus_ready = 1'b1; bus_rdata = 32'hFFFFFFFF;
        repeat (3) begin
            @(negedge clk);
            chk("idle_ready_valid", 32'(bus_valid), 32'd0);
            chk("idle_ready_rdata", rdata, 32'd0);
            chk("idle_ready_fault", 32'(fault), 32'd0);
        end
        bus_ready = 1'b0;

        run_vec(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
